multiline_reader: RTL and testbench
===================================

// Module: multiline_reader
// PURPOSE
//  Parametrised successor line capture: stores each visible video line into a ring of NUM_LINES
//  line buffers and (optionally) builds a per-frame, double-banked, saturating intensity histogram.
//  Both are readable over the 64-bit video-memory (vm_*) bus. Sits between the video timing decoder and the host bridge.
// PARAMETERS
//  PIX_W        12   pixel width in bits (1..16)
//  LINE_LEN     512  max pixels stored per line (multiple of 4)
//  NUM_LINES    2    line buffers in ring (power of 2, >=2)
//  HBIN_LOG2    8    log2 histogram bins; bin = pixel[PIX_W-1 -: HBIN_LOG2]
//  HCNT_W       27   histogram counter width (<=32)
//  localparam LW_AW = $clog2(NUM_LINES*LINE_LEN/4); VM_AW = 1 + max(LW_AW, HBIN_LOG2)
// PORTS
//  clk                  in   1      system clock
//  rst                  in   1      asynchronous, active-low reset
//  vid_pixel            in   PIX_W  pixel, valid when vid_pixsync
//  vid_pixsync          in   1      pixel strobe; one clk wide, >=2 clk apart
//  vid_hblank/vid_vblank/vid_visible in 1 each  timing flags, sampled on vid_pixsync
//  vm_address           in   VM_AW  MSB 1=histogram, 0=line words
//  vm_bus_enable, vm_rw in   1 each read request = both high
//  vm_acknowledge       out  1      one-clk ack pulse; vm_read_data valid that cycle
//  vm_read_data         out  64     read word
//  status_line_idx      out  log2(NUM_LINES)  buffer holding most recently completed line
//  status_line_len      out  log2(LINE_LEN)+1 pixels stored in that line
//  status_line_ovf      out  1      that line exceeded LINE_LEN (extra pixels dropped)
//  status_which_histo   out  1      bank currently being accumulated (other bank = last frame)
// BEHAVIOUR
//  Reset: all outputs 0; line FSM=VBLANK; histogram FSM=CLEAR (bank 0), write ptr 0.
//  vm read: request rising edge (req && !req_q) samples vm_address; next clk ack=1 with data.
//   Request held high beyond that produces no further ack; ack only after request drops and re-rises.
//   Line word: addr[LW_AW-1:0]={buffer,word}; 4 pixels, pixel k in bits [16k+15 -: PIX_W], low bits 0.
//   Histo word: addr[HBIN_LOG2-1:0]={bank,pair}; bin 2p in [HCNT_W-1:0], 2p+1 in [32+HCNT_W-1:32], zero-ext.
//   Out-of-range line address returns 0; ack still given.
//  Line FSM (advances only on vid_pixsync): VBLANK->VISIBLE on vid_visible; VISIBLE writes pixel at
//   {wr_buf,xpos}, xpos++ while xpos<LINE_LEN else drop and set line ovf; VISIBLE->VBLANK if vblank
//   (priority over hblank), ->HBLANK if hblank; on leaving VISIBLE: latch len/ovf, status_line_idx<=wr_buf,
//   wr_buf<=wr_buf+1 mod NUM_LINES (wraps), xpos<=0. HBLANK->VBLANK on vblank, ->VISIBLE on !hblank.
//   The pixel that carries the blank flag is still written (matches previous generation).
//  Histogram FSM: CLEAR (write 0 to every bin of active bank, 1 bin/clk, 2^HBIN_LOG2 clk) -> VBLANK;
//   VBLANK->READ on pixsync&&visible; READ: on pixsync read bin, capture pixel+flags -> WRITE;
//   WRITE: bin<=min(bin+1, 2^HCNT_W-1) (saturate, never wrap); then hblank->HBLANK, vblank->flip
//   status_which_histo and CLEAR, else READ. HBLANK: pixsync&&vblank -> flip+CLEAR; pixsync&&!hblank -> READ.
//   Pixels arriving during CLEAR are not counted.
//  Host reads use a separate RAM port; simultaneous host read and video write to same word return old data.
//  Reset mid-line/mid-clear: state abandoned; clear restarts from bin 0 on release.
// CONFIGURATION
//  MULTILINE_READER_HISTO_EN defined: histogram RAM, FSM, status_which_histo present.
//  Undefined: no histogram logic; histogram-region reads return 0 with normal ack; status_which_histo tied 0.
// STRUCTURE
//  Package multiline_reader_pkg: line FSM enum, histogram FSM enum, lane-packing constants (16/32-bit lanes).
//  Sub-module histo_engine: histogram FSM + dual-port bank RAM + saturating incrementer.
//  Line RAM inferred in top (write 1 pixel/clk, read 4 pixels/word).
// TESTING
//  Defaults; 3 lines of 100 pixels (value=index<<4) -> status_line_idx 0,1,0; len=100; word 1 of buf 1 = pixels 4..7.
//  Line of 600 pixels, LINE_LEN=512 -> len=512, ovf=1; next 10-pixel line -> ovf=0, len=10.
//  Frame of 300 pixels all 0xFF0 then vblank -> which_histo flips; old-bank bin 0xFF reads 300, others 0.
//  HCNT_W=4, 20 equal pixels -> bin reads 15 (saturated); new bank reads all 0 after clear.
//  vm request held high 5 clk -> exactly one ack, 1 clk after rising edge; drop+re-raise -> second ack.
//  Build without MULTILINE_READER_HISTO_EN -> histogram reads ack with 0; line tests unchanged.

Source files
------------

// File: rtl/multiline_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multiline_reader_pkg
//  Description : Shared types and constants for the multi-line capture block:
//                line and histogram state encodings, read-word lane geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package multiline_reader_pkg;

   // Line capture states
   typedef enum logic [1:0] {
      LS_VBLANK  = 2'd0,
      LS_VISIBLE = 2'd1,
      LS_HBLANK  = 2'd2
   } line_state_t;

   // Histogram engine states
   typedef enum logic [2:0] {
      HS_CLEAR  = 3'd0,
      HS_VBLANK = 3'd1,
      HS_READ   = 3'd2,
      HS_WRITE  = 3'd3,
      HS_HBLANK = 3'd4
   } histo_state_t;

   // Read-word packing: four 16-bit pixel lanes or two 32-bit counter lanes
   localparam int c_PIX_LANE_W = 16;
   localparam int c_PIX_LANES  = 4;
   localparam int c_CNT_LANE_W = 32;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multiline_reader_histo_engine.sv
`default_nettype none
// ============================================================================
//  Module      : histo_engine
//  Description : Double-banked saturating intensity histogram. One bank is
//                accumulated while the other holds the previous frame. Each
//                bank is split into even/odd bin halves so the host reads a
//                bin pair per access. Built only with MULTILINE_READER_HISTO_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`ifdef MULTILINE_READER_HISTO_EN
module histo_engine
   import multiline_reader_pkg::*;
#(
   parameter int HBIN_LOG2 = 8,
   parameter int HCNT_W    = 27
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [HBIN_LOG2-1:0] pix_bin,
   input  logic                 vid_pixsync,
   input  logic                 vid_hblank,
   input  logic                 vid_vblank,
   input  logic                 vid_visible,
   input  logic                 host_rd,
   input  logic [HBIN_LOG2-1:0] host_addr,
   output logic [HCNT_W-1:0]    host_even,
   output logic [HCNT_W-1:0]    host_odd,
   output logic                 which_histo
);

   localparam int                c_DEPTH = 1 << HBIN_LOG2;
   localparam logic [HCNT_W-1:0] c_SAT   = '1;

   histo_state_t          r_st, w_st_next;
   logic                  r_bank;
   logic [HBIN_LOG2-1:0]  r_clr;
   logic [HBIN_LOG2-1:0]  r_bin;
   logic                  r_hb, r_vb;
   logic                  w_flip;
   logic [1:0]            w_we;
   logic [HBIN_LOG2-1:0]  w_addr;
   logic [HCNT_W-1:0]     w_wdata;
   logic [HCNT_W-1:0]     w_cur;
   logic [HCNT_W-1:0]     w_eng  [2];
   logic [HCNT_W-1:0]     w_host [2];

   assign w_cur       = r_bin[0] ? w_eng[1] : w_eng[0];
   assign host_even   = w_host[0];
   assign host_odd    = w_host[1];
   assign which_histo = r_bank;

   // Next state plus engine RAM port control (address, write enables, data)
   always_comb begin
      w_st_next = r_st;
      w_addr    = {r_bank, r_bin[HBIN_LOG2-1:1]};
      w_we      = 2'b00;
      w_wdata   = '0;
      w_flip    = 1'b0;
      case (r_st)
         HS_CLEAR: begin
            w_addr = {r_bank, r_clr[HBIN_LOG2-1:1]};
            w_we   = r_clr[0] ? 2'b10 : 2'b01;
            if (r_clr == '1) w_st_next = HS_VBLANK;
         end
         HS_VBLANK: begin
            if (vid_pixsync && vid_visible) w_st_next = HS_READ;
         end
         HS_READ: begin
            // Address from the live pixel so the count is ready next cycle
            w_addr = {r_bank, pix_bin[HBIN_LOG2-1:1]};
            if (vid_pixsync) w_st_next = HS_WRITE;
         end
         HS_WRITE: begin
            w_we    = r_bin[0] ? 2'b10 : 2'b01;
            w_wdata = (w_cur == c_SAT) ? c_SAT : w_cur + 1'b1;
            if (r_hb) begin
               w_st_next = HS_HBLANK;
            end else if (r_vb) begin
               w_st_next = HS_CLEAR;
               w_flip    = 1'b1;
            end else begin
               w_st_next = HS_READ;
            end
         end
         HS_HBLANK: begin
            if (vid_pixsync && vid_vblank) begin
               w_st_next = HS_CLEAR;
               w_flip    = 1'b1;
            end else if (vid_pixsync && !vid_hblank) begin
               w_st_next = HS_READ;
            end
         end
         default: w_st_next = HS_CLEAR;
      endcase
   end

   // State register, clear pointer, bank select and captured pixel/flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_st   <= HS_CLEAR;
         r_bank <= 1'b0;
         r_clr  <= '0;
         r_bin  <= '0;
         r_hb   <= 1'b0;
         r_vb   <= 1'b0;
      end else begin
         r_st <= w_st_next;
         if (r_st == HS_CLEAR) r_clr <= r_clr + 1'b1;
         if (w_flip) r_bank <= ~r_bank;
         if (r_st == HS_READ && vid_pixsync) begin
            r_bin <= pix_bin;
            r_hb  <= vid_hblank;
            r_vb  <= vid_vblank;
         end
      end
   end

   for (genvar h = 0; h < 2; h++) begin : g_half
      logic [HCNT_W-1:0] r_mem [0:c_DEPTH-1];
      logic [HCNT_W-1:0] r_eng_q;
      logic [HCNT_W-1:0] r_host_q;

      // Engine read/write port and independent host read port (read-old)
      always_ff @(posedge clk) begin
         if (w_we[h]) r_mem[w_addr] <= w_wdata;
         r_eng_q <= r_mem[w_addr];
         if (host_rd) r_host_q <= r_mem[host_addr];
      end

      assign w_eng[h]  = r_eng_q;
      assign w_host[h] = r_host_q;
   end

endmodule
`endif
`default_nettype wire

// File: rtl/multiline_reader.sv
`default_nettype none
// ============================================================================
//  Module      : multiline_reader
//  Description : Captures each visible video line into a ring of NUM_LINES
//                line buffers and serves them over the 64-bit vm_* read bus.
//                Define MULTILINE_READER_HISTO_EN to add the per-frame
//                double-banked intensity histogram (histo_engine).
//  Revision    : 1.0  initial release
// ============================================================================
module multiline_reader
   import multiline_reader_pkg::*;
#(
   parameter  int PIX_W     = 12,
   parameter  int LINE_LEN  = 512,
   parameter  int NUM_LINES = 2,
   parameter  int HBIN_LOG2 = 8,
   parameter  int HCNT_W    = 27,
   localparam int LW_AW     = $clog2(NUM_LINES * LINE_LEN / 4),
   localparam int VM_AW     = 1 + max2(LW_AW, HBIN_LOG2),
   localparam int IDX_W     = $clog2(NUM_LINES),
   localparam int LEN_W     = $clog2(LINE_LEN) + 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [PIX_W-1:0]  vid_pixel,
   input  logic              vid_pixsync,
   input  logic              vid_hblank,
   input  logic              vid_vblank,
   input  logic              vid_visible,
   input  logic [VM_AW-1:0]  vm_address,
   input  logic              vm_bus_enable,
   input  logic              vm_rw,
   output logic              vm_acknowledge,
   output logic [63:0]       vm_read_data,
   output logic [IDX_W-1:0]  status_line_idx,
   output logic [LEN_W-1:0]  status_line_len,
   output logic              status_line_ovf,
   output logic              status_which_histo
);

   localparam int c_WORD_AW = LW_AW - IDX_W;
   localparam int c_WORDS   = LINE_LEN / 4;
   localparam int c_DEPTH   = 1 << LW_AW;

   line_state_t         r_ls, w_ls_next;
   logic [IDX_W-1:0]    r_wr_buf;
   logic [LEN_W-1:0]    r_xpos;
   logic                r_ovf;
   logic                w_room, w_in_vis, w_leave, w_we;
   logic [LW_AW-1:0]    w_wr_addr, w_rd_addr;
   logic                r_req_q, w_req, w_req_rise;
   logic                r_ack, r_sel_histo, r_line_ok, w_line_ok;
   logic [63:0]         w_line_word, w_histo_word;
   logic [HCNT_W-1:0]   w_hist_even, w_hist_odd;

   assign w_room     = r_xpos < LEN_W'(LINE_LEN);
   assign w_in_vis   = vid_pixsync && (r_ls == LS_VISIBLE);
   assign w_leave    = w_in_vis && (vid_vblank || vid_hblank);
   assign w_we       = w_in_vis && w_room;
   assign w_wr_addr  = {r_wr_buf, r_xpos[LEN_W-2:2]};
   assign w_rd_addr  = vm_address[LW_AW-1:0];
   assign w_req      = vm_bus_enable && vm_rw;
   assign w_req_rise = w_req && !r_req_q;
   assign w_line_ok  = ((vm_address[VM_AW-2:0] >> LW_AW) == '0) &&
                       (int'(vm_address[c_WORD_AW-1:0]) < c_WORDS);

   // Line state transitions, evaluated only on pixel strobes
   always_comb begin
      w_ls_next = r_ls;
      if (vid_pixsync) begin
         case (r_ls)
            LS_VBLANK:  if (vid_visible) w_ls_next = LS_VISIBLE;
            LS_VISIBLE: begin
               if (vid_vblank)      w_ls_next = LS_VBLANK;
               else if (vid_hblank) w_ls_next = LS_HBLANK;
            end
            LS_HBLANK: begin
               if (vid_vblank)       w_ls_next = LS_VBLANK;
               else if (!vid_hblank) w_ls_next = LS_VISIBLE;
            end
            default: w_ls_next = LS_VBLANK;
         endcase
      end
   end

   // Line state, write position and completed-line status; the blanking
   // pixel itself is stored, so it counts toward the latched length
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ls            <= LS_VBLANK;
         r_wr_buf        <= '0;
         r_xpos          <= '0;
         r_ovf           <= 1'b0;
         status_line_idx <= '0;
         status_line_len <= '0;
         status_line_ovf <= 1'b0;
      end else begin
         r_ls <= w_ls_next;
         if (w_leave) begin
            status_line_len <= w_room ? r_xpos + 1'b1 : r_xpos;
            status_line_ovf <= r_ovf | !w_room;
            status_line_idx <= r_wr_buf;
            r_wr_buf        <= r_wr_buf + 1'b1;
            r_xpos          <= '0;
            r_ovf           <= 1'b0;
         end else if (w_in_vis) begin
            if (w_room) r_xpos <= r_xpos + 1'b1;
            else        r_ovf  <= 1'b1;
         end
      end
   end

   // Host request edge detect; ack follows the rising edge by one clock
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_req_q     <= 1'b0;
         r_ack       <= 1'b0;
         r_sel_histo <= 1'b0;
         r_line_ok   <= 1'b0;
      end else begin
         r_req_q <= w_req;
         r_ack   <= w_req_rise;
         if (w_req_rise) begin
            r_sel_histo <= vm_address[VM_AW-1];
            r_line_ok   <= w_line_ok;
         end
      end
   end

   // Line RAM as four pixel lanes: one lane written per pixel, all read per word
   for (genvar k = 0; k < c_PIX_LANES; k++) begin : g_lane
      logic [PIX_W-1:0] r_mem [0:c_DEPTH-1];
      logic [PIX_W-1:0] r_rd;

      always_ff @(posedge clk) begin
         if (w_we && (r_xpos[1:0] == 2'(k))) r_mem[w_wr_addr] <= vid_pixel;
         if (w_req_rise) r_rd <= r_mem[w_rd_addr];
      end

      // Pixel left-justified in its lane, low bits zero
      assign w_line_word[c_PIX_LANE_W*k +: c_PIX_LANE_W] =
         c_PIX_LANE_W'(r_rd) << (c_PIX_LANE_W - PIX_W);
   end

`ifdef MULTILINE_READER_HISTO_EN
   histo_engine #(
      .HBIN_LOG2 (HBIN_LOG2),
      .HCNT_W    (HCNT_W)
   ) u_histo (
      .clk         (clk),
      .rst         (rst),
      .pix_bin     (vid_pixel[PIX_W-1 -: HBIN_LOG2]),
      .vid_pixsync (vid_pixsync),
      .vid_hblank  (vid_hblank),
      .vid_vblank  (vid_vblank),
      .vid_visible (vid_visible),
      .host_rd     (w_req_rise),
      .host_addr   (vm_address[HBIN_LOG2-1:0]),
      .host_even   (w_hist_even),
      .host_odd    (w_hist_odd),
      .which_histo (status_which_histo)
   );
`else
   assign w_hist_even        = '0;
   assign w_hist_odd         = '0;
   assign status_which_histo = 1'b0;
`endif

   assign w_histo_word   = {c_CNT_LANE_W'(w_hist_odd), c_CNT_LANE_W'(w_hist_even)};
   assign vm_acknowledge = r_ack;

   // Read data is only driven during the ack cycle; RAM outputs are unreset
   always_comb begin
      vm_read_data = '0;
      if (r_ack) begin
         if (r_sel_histo)    vm_read_data = w_histo_word;
         else if (r_line_ok) vm_read_data = w_line_word;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multiline_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiline_reader
//  Description : Self-checking bench for multiline_reader. Host reads are
//                scored against a queue of expected words filled when each
//                request is issued. With MULTILINE_READER_HISTO_EN a second
//                instance (HCNT_W=4) shares the stimulus to show saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multiline_reader;

`ifdef MULTILINE_READER_HISTO_EN
   localparam bit c_HEN = 1'b1;
`else
   localparam bit c_HEN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] vid_pixel = '0;
   logic        vid_pixsync = 1'b0, vid_hblank = 1'b0, vid_vblank = 1'b0, vid_visible = 1'b0;
   logic [8:0]  vm_address = '0;
   logic        vm_bus_enable = 1'b0, vm_rw = 1'b0;
   logic        vm_acknowledge;
   logic [63:0] vm_read_data;
   logic [0:0]  status_line_idx;
   logic [9:0]  status_line_len;
   logic        status_line_ovf, status_which_histo;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_ack    = 0;
   logic [63:0] exp_q[$];
   logic [63:0] exp2_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   multiline_reader dut (
      .clk(clk), .rst(rst),
      .vid_pixel(vid_pixel), .vid_pixsync(vid_pixsync), .vid_hblank(vid_hblank),
      .vid_vblank(vid_vblank), .vid_visible(vid_visible),
      .vm_address(vm_address), .vm_bus_enable(vm_bus_enable), .vm_rw(vm_rw),
      .vm_acknowledge(vm_acknowledge), .vm_read_data(vm_read_data),
      .status_line_idx(status_line_idx), .status_line_len(status_line_len),
      .status_line_ovf(status_line_ovf), .status_which_histo(status_which_histo)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every ack pops the oldest expected word
   always @(negedge clk) begin
      if (vm_acknowledge === 1'b1) begin
         n_ack++;
         if (exp_q.size() == 0) check("spurious_ack", 64'(vm_acknowledge), 64'd0);
         else check(tag_q.pop_front(), vm_read_data, exp_q.pop_front());
      end
   end

`ifdef MULTILINE_READER_HISTO_EN
   logic        ack2;
   logic [63:0] data2;
   logic [0:0]  idx2;
   logic [9:0]  len2;
   logic        ovf2, which2;

   multiline_reader #(.HCNT_W(4)) dut2 (
      .clk(clk), .rst(rst),
      .vid_pixel(vid_pixel), .vid_pixsync(vid_pixsync), .vid_hblank(vid_hblank),
      .vid_vblank(vid_vblank), .vid_visible(vid_visible),
      .vm_address(vm_address), .vm_bus_enable(vm_bus_enable), .vm_rw(vm_rw),
      .vm_acknowledge(ack2), .vm_read_data(data2),
      .status_line_idx(idx2), .status_line_len(len2),
      .status_line_ovf(ovf2), .status_which_histo(which2)
   );

   always @(negedge clk) begin
      if (ack2 === 1'b1) begin
         if (exp2_q.size() == 0) check("spurious_ack2", 64'(ack2), 64'd0);
         else check("rd_sat4", data2, exp2_q.pop_front());
      end
   end
`endif

   function automatic logic [63:0] hexp(input logic [63:0] v);
      return c_HEN ? v : 64'd0;
   endfunction

   task automatic send_pix(input logic [11:0] p, input logic hb, input logic vb, input logic vis);
      @(negedge clk);
      vid_pixel   = p;
      vid_hblank  = hb;
      vid_vblank  = vb;
      vid_visible = vis;
      vid_pixsync = 1'b1;
      @(negedge clk);
      vid_pixsync = 1'b0;
   endtask

   // One start strobe (leaves blanking, not stored) then n stored pixels;
   // the last pixel carries hblank or vblank
   task automatic send_line(input int n, input logic end_vb, input logic fixed, input logic [11:0] fv);
      logic [11:0] p;
      send_pix(12'h000, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < n; i++) begin
         p = fixed ? fv : 12'(i << 4);
         send_pix(p, (i == n - 1) && !end_vb, (i == n - 1) && end_vb, 1'b1);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_status(input string tag, input int idx, input int len, input logic ovf);
      check({tag, "_idx"}, 64'(status_line_idx), 64'(idx));
      check({tag, "_len"}, 64'(status_line_len), 64'(len));
      check({tag, "_ovf"}, 64'(status_line_ovf), 64'(ovf));
   endtask

   task automatic vm_read(input string tag, input logic [8:0] a, input logic [63:0] e,
                          input logic [63:0] e2, input int hold);
      @(negedge clk);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      exp2_q.push_back(e2);
      vm_address    = a;
      vm_bus_enable = 1'b1;
      vm_rw         = 1'b1;
      @(negedge clk);
      check({tag, "_ack_lat"}, 64'(vm_acknowledge), 64'd1);
      repeat (hold - 1) @(negedge clk);
      vm_bus_enable = 1'b0;
      vm_rw         = 1'b0;
      repeat (2) @(negedge clk);
      check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
`ifdef MULTILINE_READER_HISTO_EN
      check({tag, "_drain2"}, 64'(exp2_q.size()), 64'd0);
`endif
      exp_q.delete();
      tag_q.delete();
      exp2_q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a0;
      repeat (3) @(negedge clk);
      check("rst_ack",   64'(vm_acknowledge),     64'd0);
      check("rst_data",  vm_read_data,            64'd0);
      check("rst_idx",   64'(status_line_idx),    64'd0);
      check("rst_len",   64'(status_line_len),    64'd0);
      check("rst_ovf",   64'(status_line_ovf),    64'd0);
      check("rst_which", 64'(status_which_histo), 64'd0);
      rst = 1'b1;
      repeat (300) @(negedge clk);

      send_line(100, 1'b0, 1'b0, 12'h0);
      check_status("line1", 0, 100, 1'b0);
      send_line(100, 1'b0, 1'b0, 12'h0);
      check_status("line2", 1, 100, 1'b0);
      send_line(100, 1'b0, 1'b0, 12'h0);
      check_status("line3", 0, 100, 1'b0);

      vm_read("buf1_w1",  9'h081, 64'h0700_0600_0500_0400, 64'h0700_0600_0500_0400, 1);
      vm_read("buf0_w0",  9'h000, 64'h0300_0200_0100_0000, 64'h0300_0200_0100_0000, 1);
      vm_read("buf0_w24", 9'h018, 64'h6300_6200_6100_6000, 64'h6300_6200_6100_6000, 1);
      a0 = n_ack;
      vm_read("held", 9'h081, 64'h0700_0600_0500_0400, 64'h0700_0600_0500_0400, 5);
      check("held_acks", 64'(n_ack - a0), 64'd1);
      a0 = n_ack;
      vm_read("reraise", 9'h081, 64'h0700_0600_0500_0400, 64'h0700_0600_0500_0400, 1);
      check("reraise_acks", 64'(n_ack - a0), 64'd1);

      send_line(600, 1'b0, 1'b0, 12'h0);
      check_status("long", 1, 512, 1'b1);
      send_line(10, 1'b1, 1'b0, 12'h0);
      check_status("short", 0, 10, 1'b0);
      check("which_frame1", 64'(status_which_histo), 64'(c_HEN));
      // Bins 0 and 1 of bank 0: three 100-px lines + 600-px line (x3) + 10-px line
      vm_read("h_b0_p0", 9'h100, hexp(64'h0000_0007_0000_0007), hexp(64'h0000_0007_0000_0007), 1);

      repeat (300) @(negedge clk);
      send_line(300, 1'b1, 1'b1, 12'hFF0);
      check_status("frame", 1, 300, 1'b0);
      check("which_frame2", 64'(status_which_histo), 64'd0);
      vm_read("h_b1_pFF", 9'h1FF, hexp(64'd300 << 32), hexp(64'd15 << 32), 1);
      vm_read("h_b1_pFE", 9'h1FE, 64'd0, 64'd0, 1);
      vm_read("h_b1_p0",  9'h180, 64'd0, 64'd0, 1);
      vm_read("buf1_ff0", 9'h080, 64'hFF00_FF00_FF00_FF00, 64'hFF00_FF00_FF00_FF00, 1);

      repeat (300) @(negedge clk);
      vm_read("h_b0_p0_clr",  9'h100, 64'd0, 64'd0, 1);
      vm_read("h_b0_pFF_clr", 9'h17F, 64'd0, 64'd0, 1);

`ifdef MULTILINE_READER_HISTO_EN
      check("d2_idx",   64'(idx2),   64'd1);
      check("d2_len",   64'(len2),   64'd300);
      check("d2_ovf",   64'(ovf2),   64'd0);
      check("d2_which", 64'(which2), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
